multicycle_sequencer: RTL

Moore-style control FSM that sequences a shared MIPS datapath over several cycles per instruction. The datapath has one memory port for instruction and data, an IR, an ALUOut register and a single ALU. Each cycle the block drives that datapath's mux selects, register enables and memory strobes, waits on a memory ready handshake, and flags illegal opcodes and memory timeouts. It replaces the single-cycle opcode decoder when the core runs in multicycle mode.

---
 rtl/multicycle_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Moore control FSM sequencing a shared multicycle MIPS datapath, 2-5 cycles per instruction.
// Latency: outputs decode from the current state; only a few input-to-output paths are combinational.
// Backpressure: memory states hold on mem_ready low; a bounded wait aborts to FETCH and sets mem_err.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  logic        err_q;
  logic        in_wait;
  logic        timeout;

  assign in_wait = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
  assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_nxt;
      if (timeout) err_q <= 1'b1;
    end
  end

  // Counter only survives while parked in a memory state with the handshake low.
  always_comb begin
    wait_nxt = '0;
    if (in_wait && !mem_ready && !timeout) wait_nxt = wait_cnt + 16'd1;
  end

  always_comb begin
    nxt_state  = cur_state;
    pc_en      = 1'b0;
    pc_source  = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      unique case (cur_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          nxt_state = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          unique case (opcode)
            OP_RTYPE:       nxt_state = S_EXEC;
            OP_LW, OP_SW:   nxt_state = S_MEMADR;
            OP_BEQ, OP_BNE: nxt_state = S_BRANCH;
            OP_ADDI:        nxt_state = S_ADDIEX;
            OP_J:           nxt_state = S_JUMP;
            default: begin
              nxt_state  = S_FETCH;
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          i_or_d     = 1'b1;
          mem_read   = 1'b1;
          instr_done = timeout;
          if (mem_ready)    nxt_state = S_MEMWB;
          else if (timeout) nxt_state = S_FETCH;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end
        S_MEMWR: begin
          i_or_d     = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready || timeout;
          if (mem_ready || timeout) nxt_state = S_FETCH;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          nxt_state = S_ALUWB;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_source  = 2'b01;
          instr_done = 1'b1;
          pc_en      = zero ^ opcode[0];
          nxt_state  = S_FETCH;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_en      = 1'b1;
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end
        default: nxt_state = S_FETCH;
      endcase
    end
  end

  assign mem_err = err_q;
  assign state   = cur_state;

endmodule
